// File: rtl/paddle_tracker.sv
// Quadrature encoder to saturating paddle position, with a once-per-frame display
// latch and a registered 1-bit paddle pixel for the colour merge.
module paddle_tracker #(
    parameter int unsigned X_MAX    = 640,
    parameter int unsigned PADDLE_W = 80,
    parameter int unsigned PADDLE_Y = 440,
    parameter int unsigned PADDLE_H = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        quadA,
    input  logic        quadB,
    input  logic [10:0] CounterX,
    input  logic [8:0]  CounterY,
    output logic        paddle,
    output logic [9:0]  paddle_pos
);

    localparam int unsigned POS_W   = 10;
    localparam int unsigned X_W     = 11;
    localparam int unsigned Y_W     = 10;
    localparam int unsigned POS_MAX = X_MAX - PADDLE_W;
    localparam int unsigned POS_RST = POS_MAX / 2;

    localparam logic [POS_W-1:0] POS_MAX_V = POS_W'(POS_MAX);
    localparam logic [POS_W-1:0] POS_RST_V = POS_W'(POS_RST);
    localparam logic [Y_W-1:0]   Y_LO_V    = Y_W'(PADDLE_Y);
    localparam logic [Y_W-1:0]   Y_HI_V    = Y_W'(PADDLE_Y + PADDLE_H);
    localparam logic [X_W-1:0]   PAD_W_V   = X_W'(PADDLE_W);

    logic [2:0]       r_qa;
    logic [2:0]       r_qb;
    logic [POS_W-1:0] r_pos;
    logic [POS_W-1:0] r_disp_pos;
    logic             r_paddle;

    logic             w_en;
    logic             w_dir;
    logic [POS_W-1:0] w_pos_nxt;
    logic             w_origin;
    logic [X_W-1:0]   w_x_lo;
    logic [X_W-1:0]   w_x_hi;
    logic [Y_W-1:0]   w_y;
    logic             w_in_x;
    logic             w_in_y;

    // Synchronizers run through reset so release never sees a stale edge.
    always_ff @(posedge clk) begin
        r_qa <= {r_qa[1:0], quadA};
        r_qb <= {r_qb[1:0], quadB};
    end

    assign w_en  = r_qa[1] ^ r_qa[2] ^ r_qb[1] ^ r_qb[2];
    assign w_dir = r_qa[1] ^ r_qb[2];

    // Saturating up/down step; simultaneous phase changes cancel via w_en.
    always_comb begin
        w_pos_nxt = r_pos;
        if (w_en) begin
            if (w_dir) begin
                if (r_pos < POS_MAX_V) begin
                    w_pos_nxt = r_pos + POS_W'(1);
                end
            end else if (r_pos != '0) begin
                w_pos_nxt = r_pos - POS_W'(1);
            end
        end
    end

    assign w_origin = (CounterX == '0) && (CounterY == '0);
    assign w_x_lo   = {1'b0, r_disp_pos};
    assign w_x_hi   = w_x_lo + PAD_W_V;
    assign w_y      = {1'b0, CounterY};
    assign w_in_x   = (CounterX >= w_x_lo) && (CounterX < w_x_hi);
    assign w_in_y   = (w_y >= Y_LO_V) && (w_y < Y_HI_V);

    // disp_pos samples the pre-update pos when the origin coincides with a step.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pos      <= POS_RST_V;
            r_disp_pos <= POS_RST_V;
            r_paddle   <= 1'b0;
        end else begin
            r_pos    <= w_pos_nxt;
            r_paddle <= w_in_x && w_in_y;
            if (w_origin) begin
                r_disp_pos <= r_pos;
            end
        end
    end

    assign paddle     = r_paddle;
    assign paddle_pos = r_pos;

endmodule
